mackerel_bus_controller: RTL
============================

// Module: mackerel_bus_controller
// PURPOSE
// Parametrised 68000 bus controller for the Mackerel system CPLD. Provides chip-select decode,
// a boot ROM overlay, internal DTACK wait-state generation, a bus-error watchdog, prioritised IPL
// encoding and interrupt-acknowledge steering. Sits between the CPU and ROM, SRAM, DUART and expansion.
// PARAMETERS
// CLK_DIV_LOG2     1          CLK_CPU = CLK / 2**CLK_DIV_LOG2, range 1..4
// BOOT_CYCLES      4          number of bus cycles after reset with ROM overlaid on every address
// ROM_BASE/ROM_END 24'hE00000/24'hF00000   ROM window, [base,end)
// RAM_END          24'h100000 SRAM window, [0,end)
// DUART_BASE/_END  24'hC00000/24'hD00000   DUART window
// EXP_BASE/_END    24'h100000/24'h900000   expansion/DRAM window
// ROM_WAIT         1          wait count before internal DTACK for ROM, range 0..15
// RAM_WAIT         0          wait count for SRAM, range 0..15
// BERR_TIMEOUT     255        WAIT cycles before BERR; 8-bit counter
// DUART_LEVEL      1          interrupt level of the DUART, range 1..7
// PORTS
// CLK          in   1   source oscillator; all registers update on its rising edge
// RST          in   1   asynchronous, active-high reset
// CLK_CPU      out  1   divided CPU clock
// AS,UDS,LDS   in   1   active-low CPU strobes
// RW           in   1   1 = read
// FC           in   3   CPU function code
// ADDR         in   23  CPU address bits [23:1]
// ROM_LOWER,ROM_UPPER,RAM_LOWER,RAM_UPPER  out 1  active-low byte-lane chip selects
// DUART,EXP    out  1   active-low device selects
// DTACK_DUART,DTACK_EXP  in  1   active-low device acknowledges
// IRQ          in   7   [7:1], active-low; bit n requests level n
// IPL          out  3   active-low encoded priority level to CPU
// IACK_DUART   out  1   active-low
// DTACK,BERR,VPA  out 1 active-low, to CPU
// BOOT         out  1   1 = overlay finished
// BEHAVIOUR
// - Reset values: CLK_CPU=0, divider=0, BOOT=0, boot count=0, FSM=IDLE, DTACK=BERR=VPA=1, IPL=3'b111.
// - AS is synchronised through two flops (as_s). Cycle start = edge where as_s goes 1->0.
// - Chip selects are combinational from the raw strobes, with no latency. iack = (FC==3'b111).
//   - BOOT=0: ROM is selected for every non-iack access; all other selects are inactive.
//   - BOOT=1: parameter windows apply, all gated by ~iack. Priority on overlap: ROM > RAM > DUART > EXP.
//   - Byte-lane selects are qualified by UDS/LDS respectively. DUART and EXP require AS plus either data strobe.
// - IACK: level = ADDR[3:1]. IACK_DUART=0 while AS=0 && iack && level==DUART_LEVEL.
// - FSM states: IDLE, WAIT, ACK, FAULT.
//   - On cycle start: IDLE->WAIT, with wait count=0 and watchdog=0.
//   - WAIT, ROM/RAM target: count increments; when count==*_WAIT, go to ACK. DTACK falls *_WAIT+1 edges after the start edge.
//   - WAIT, DUART/EXP/DUART-IACK target: each device DTACK is registered once; go to ACK on the edge where the registered value=0.
//   - WAIT, unmapped target: remain in WAIT until timeout.
//   - ACK: DTACK=0 (registered from state). Exit to IDLE on the edge where as_s=1.
//   - Watchdog increments every WAIT cycle. When it equals BERR_TIMEOUT, go to FAULT. If ack and timeout occur on the same edge, ACK wins.
//   - FAULT: BERR=0 and DTACK=1 until as_s=1, then IDLE.
//   - as_s=1 while in WAIT (aborted cycle): go to IDLE with no DTACK and no BERR.
// - Boot count increments on each as_s 0->1 while BOOT=0. BOOT becomes 1 on the edge that ends the
//   BOOT_CYCLES-th cycle; the count then saturates. BOOT stays 1 until RST.
// - IPL: registered once per CLK. It carries the inverted level of the highest asserted IRQ (level 5 -> 3'b010); no request -> 3'b111.
// - RST asserted mid-cycle: all state returns to reset values immediately, and the overlay restarts.
// CONFIGURATION
// - AUTOVEC_EN defined: an iack cycle whose level != DUART_LEVEL drives VPA=0 while AS=0. The FSM
//   holds in WAIT without a watchdog count and returns to IDLE when as_s=1.
// - AUTOVEC_EN undefined: VPA is tied to 1, and such iack cycles are treated as unmapped, ending in BERR.
// TESTING
// 1. Release reset, then 4 word reads at 0x000000: ROM_LOWER/ROM_UPPER go low on each.
//    A 5th read at the same address selects RAM_LOWER/RAM_UPPER, with BOOT=1.
// 2. Word read at 0xE00010 (ROM_WAIT=1): DTACK falls 2 CLK after the start edge and rises on the edge where as_s=1.
// 3. Read at 0x500000 with DTACK_EXP held at 1: BERR falls after 255 WAIT cycles while DTACK stays 1.
//    BERR rises once AS returns high.
// 4. IRQ[5]=0 and IRQ[2]=0 give IPL=3'b010. Releasing IRQ[5] gives IPL=3'b101 one CLK later.
// 5. FC=3'b111, ADDR[3:1]=1: IACK_DUART=0, and DTACK follows DTACK_DUART.
//    With ADDR[3:1]=4: VPA=0 if AUTOVEC_EN is defined, otherwise BERR=0 after the timeout.
// 6. CLK_DIV_LOG2=2: CLK_CPU period is 4 CLK. Pulsing RST during WAIT forces DTACK=1, BOOT=0, IPL=3'b111 without waiting for a clock edge.

Source files
------------

// File: rtl/mackerel_bus_controller.sv
// Mackerel 68000 bus controller: chip-select decode, boot overlay, DTACK/BERR generation, IPL encode.
// Optional autovector support (VPA on non-DUART interrupt acknowledges) is enabled by defining AUTOVEC_EN.
module mackerel_bus_controller #(
  parameter int          CLK_DIV_LOG2 = 1,
  parameter int          BOOT_CYCLES  = 4,
  parameter logic [23:0] ROM_BASE     = 24'hE00000,
  parameter logic [23:0] ROM_END      = 24'hF00000,
  parameter logic [23:0] RAM_END      = 24'h100000,
  parameter logic [23:0] DUART_BASE   = 24'hC00000,
  parameter logic [23:0] DUART_END    = 24'hD00000,
  parameter logic [23:0] EXP_BASE     = 24'h100000,
  parameter logic [23:0] EXP_END      = 24'h900000,
  parameter int          ROM_WAIT     = 1,
  parameter int          RAM_WAIT     = 0,
  parameter int          BERR_TIMEOUT = 255,
  parameter int          DUART_LEVEL  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        CLK_CPU,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [2:0]  FC,
  input  logic [23:1] ADDR,
  output logic        ROM_LOWER,
  output logic        ROM_UPPER,
  output logic        RAM_LOWER,
  output logic        RAM_UPPER,
  output logic        DUART,
  output logic        EXP,
  input  logic        DTACK_DUART,
  input  logic        DTACK_EXP,
  input  logic [7:1]  IRQ,
  output logic [2:0]  IPL,
  output logic        IACK_DUART,
  output logic        DTACK,
  output logic        BERR,
  output logic        VPA,
  output logic        BOOT
);

  localparam int BCW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_FAULT} state_t;
  typedef enum logic [2:0] {T_NONE, T_ROM, T_RAM, T_DUART, T_EXP, T_IACK, T_AUTO} target_t;

  function automatic logic [2:0] encode_ipl(input logic [7:1] req);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 1; i <= 7; i++)
      if (!req[i]) lvl = 3'(i);
    return ~lvl;
  endfunction

  logic [CLK_DIV_LOG2-1:0] div;
  logic                    as_meta, as_s;
  logic                    dtack_duart_r, dtack_exp_r;
  logic [BCW-1:0]          boot_cnt;
  logic                    boot;
  logic [2:0]              ipl_r;
  state_t                  state;
  target_t                 target;
  logic [3:0]              wait_cnt;
  logic [7:0]              wdog;
  logic                    dtack_r, berr_r;

  logic [23:0] byte_addr;
  logic        iack, iack_duart_lvl;
  logic        rom_hit, ram_hit, duart_hit, exp_hit;
  logic        as_fall, as_rise;
  target_t     dec_target;
  logic        wait_ack;
  logic        unused_ok;

  assign byte_addr      = {ADDR, 1'b0};
  assign iack           = (FC == 3'b111);
  assign iack_duart_lvl = iack && (ADDR[3:1] == 3'(DUART_LEVEL));
  assign as_fall        = as_s & ~as_meta;
  assign as_rise        = ~as_s & as_meta;
  assign unused_ok      = RW;

  // Address decode: overlay maps everything to ROM until the boot cycles have run.
  always_comb begin
    rom_hit   = 1'b0;
    ram_hit   = 1'b0;
    duart_hit = 1'b0;
    exp_hit   = 1'b0;
    if (!boot)
      rom_hit = ~iack;
    else if (!iack) begin
      if (byte_addr >= ROM_BASE && byte_addr < ROM_END)          rom_hit   = 1'b1;
      else if (byte_addr < RAM_END)                              ram_hit   = 1'b1;
      else if (byte_addr >= DUART_BASE && byte_addr < DUART_END) duart_hit = 1'b1;
      else if (byte_addr >= EXP_BASE && byte_addr < EXP_END)     exp_hit   = 1'b1;
    end
  end

  always_comb begin
    dec_target = T_NONE;
    if (iack) begin
      if (iack_duart_lvl) dec_target = T_IACK;
`ifdef AUTOVEC_EN
      else                dec_target = T_AUTO;
`endif
    end
    else if (rom_hit)   dec_target = T_ROM;
    else if (ram_hit)   dec_target = T_RAM;
    else if (duart_hit) dec_target = T_DUART;
    else if (exp_hit)   dec_target = T_EXP;
  end

  assign ROM_LOWER  = ~(rom_hit & ~LDS);
  assign ROM_UPPER  = ~(rom_hit & ~UDS);
  assign RAM_LOWER  = ~(ram_hit & ~LDS);
  assign RAM_UPPER  = ~(ram_hit & ~UDS);
  assign DUART      = ~(duart_hit & ~AS & (~UDS | ~LDS));
  assign EXP        = ~(exp_hit & ~AS & (~UDS | ~LDS));
  assign IACK_DUART = ~(~AS & iack_duart_lvl);
`ifdef AUTOVEC_EN
  assign VPA        = ~(~AS & iack & ~iack_duart_lvl);
`else
  assign VPA        = 1'b1;
`endif

  assign CLK_CPU = div[CLK_DIV_LOG2-1];
  assign BOOT    = boot;
  assign IPL     = ipl_r;
  assign DTACK   = dtack_r;
  assign BERR    = berr_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div           <= '0;
      as_meta       <= 1'b1;
      as_s          <= 1'b1;
      dtack_duart_r <= 1'b1;
      dtack_exp_r   <= 1'b1;
      ipl_r         <= 3'b111;
      boot_cnt      <= '0;
      boot          <= 1'b0;
    end else begin
      div           <= div + CLK_DIV_LOG2'(1);
      as_meta       <= AS;
      as_s          <= as_meta;
      dtack_duart_r <= DTACK_DUART;
      dtack_exp_r   <= DTACK_EXP;
      ipl_r         <= encode_ipl(IRQ);
      if (!boot && as_rise) begin
        boot_cnt <= boot_cnt + BCW'(1);
        if (boot_cnt == BCW'(BOOT_CYCLES - 1)) boot <= 1'b1;
      end
    end
  end

  always_comb begin
    case (target)
      T_ROM:          wait_ack = (wait_cnt == 4'(ROM_WAIT));
      T_RAM:          wait_ack = (wait_cnt == 4'(RAM_WAIT));
      T_DUART, T_IACK: wait_ack = ~dtack_duart_r;
      T_EXP:          wait_ack = ~dtack_exp_r;
      default:        wait_ack = 1'b0;
    endcase
  end

  // Cycle FSM; ack is checked before the watchdog so a simultaneous ack wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      target   <= T_NONE;
      wait_cnt <= '0;
      wdog     <= '0;
      dtack_r  <= 1'b1;
      berr_r   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (as_fall) begin
          state    <= S_WAIT;
          target   <= dec_target;
          wait_cnt <= '0;
          wdog     <= '0;
        end
        S_WAIT: begin
          if (as_meta)
            state <= S_IDLE;
          else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_ack) begin
              state   <= S_ACK;
              dtack_r <= 1'b0;
            end else if (target != T_AUTO) begin
              wdog <= wdog + 8'd1;
              if (wdog + 8'd1 == 8'(BERR_TIMEOUT)) begin
                state  <= S_FAULT;
                berr_r <= 1'b0;
              end
            end
          end
        end
        S_ACK: if (as_meta) begin
          state   <= S_IDLE;
          dtack_r <= 1'b1;
        end
        S_FAULT: if (as_meta) begin
          state  <= S_IDLE;
          berr_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
